// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the MIPS-subset CPU: sequences fetch/decode/execute/
// memory/write-back and drives datapath strobes; memory waits are guarded by a watchdog.
module mc_control_fsm #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CW             = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] i_opcode,
   input  logic [4:0] i_rt,
   input  logic [4:0] i_rd,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_ir_wen,
   output logic       o_pc_wen,
   output logic [1:0] o_pc_src,
   output logic       o_tgt_wen,
   output logic       o_iord,
   output logic       o_mem_ren,
   output logic       o_mem_wen,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic       o_reg_wen,
   output logic [4:0] o_wreg,
   output logic       o_mem_to_reg,
   output logic [3:0] o_state,
   output logic       o_instr_done,
   output logic       o_illegal,
   output logic       o_fault
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC   = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWR  = 4'd4;
   localparam logic [3:0] S_WB     = 4'd5;
   localparam logic [3:0] S_BRANCH = 4'd6;
   localparam logic [3:0] S_JUMP   = 4'd7;
   localparam logic [3:0] S_HALT   = 4'd8;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   localparam logic [CW-1:0] W_TIMEOUT = CW'(TIMEOUT_CYCLES);

   logic [3:0]    r_state;
   logic [3:0]    w_next;
   logic [CW-1:0] r_wd_cnt;
   logic          r_fault;

   logic       w_is_rtype;
   logic       w_legal;
   logic       w_wait_state;
   logic       w_timeout;
   logic [4:0] w_wreg;

   logic w_ir_wen, w_pc_wen, w_tgt_wen, w_mem_ren, w_mem_wen;
   logic w_reg_wen, w_instr_done, w_illegal;

   assign w_is_rtype   = (i_opcode == OP_R);
   assign w_legal      = w_is_rtype || (i_opcode == OP_ADDI) || (i_opcode == OP_LW) ||
                         (i_opcode == OP_SW) || (i_opcode == OP_BEQ) || (i_opcode == OP_J);
   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   // A ready arriving on the limit cycle still completes normally.
   assign w_timeout    = w_wait_state && !i_mem_ready && (r_wd_cnt == W_TIMEOUT);
   assign w_wreg       = w_is_rtype ? i_rd : i_rt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_FETCH;
         r_wd_cnt <= '0;
         r_fault  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wd_cnt <= '0;
         else if (w_wait_state && !i_mem_ready)
            r_wd_cnt <= r_wd_cnt + CW'(1);
         if (w_timeout)
            r_fault <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = S_HALT;
      end else begin
         case (r_state)
            S_FETCH:  if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
               case (i_opcode)
                  OP_R, OP_ADDI, OP_LW, OP_SW: w_next = S_EXEC;
                  OP_BEQ:                      w_next = S_BRANCH;
                  OP_J:                        w_next = S_JUMP;
                  default:                     w_next = S_FETCH;
               endcase
            end
            S_EXEC: begin
               case (i_opcode)
                  OP_LW:         w_next = S_MEMRD;
                  OP_SW:         w_next = S_MEMWR;
                  OP_R, OP_ADDI: w_next = S_WB;
                  default:       w_next = S_FETCH;
               endcase
            end
            S_MEMRD:                   if (i_mem_ready) w_next = S_WB;
            S_MEMWR:                   if (i_mem_ready) w_next = S_FETCH;
            S_WB, S_BRANCH, S_JUMP:    w_next = S_FETCH;
            S_HALT:                    w_next = S_HALT;
            default:                   w_next = S_FETCH;
         endcase
      end
   end

   always_comb begin
      w_ir_wen     = 1'b0;
      w_pc_wen     = 1'b0;
      w_tgt_wen    = 1'b0;
      w_mem_ren    = 1'b0;
      w_mem_wen    = 1'b0;
      w_reg_wen    = 1'b0;
      w_instr_done = 1'b0;
      w_illegal    = 1'b0;
      o_pc_src     = 2'b00;
      o_iord       = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_alu_op     = 2'b00;
      o_mem_to_reg = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_ren   = 1'b1;
            o_alu_src_b = 2'b01;
            w_ir_wen    = i_mem_ready;
            w_pc_wen    = i_mem_ready;
         end
         S_DECODE: begin
            o_alu_src_b = 2'b11;
            w_tgt_wen   = 1'b1;
            w_illegal   = !w_legal;
         end
         S_EXEC: begin
            o_alu_src_a = 1'b1;
            if (w_is_rtype) o_alu_op    = 2'b10;
            else            o_alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            w_mem_ren = 1'b1;
            o_iord    = 1'b1;
         end
         S_MEMWR: begin
            w_mem_wen    = 1'b1;
            o_iord       = 1'b1;
            w_instr_done = i_mem_ready;
         end
         S_WB: begin
            // $0 is not hardwired in the register file, so never write it.
            w_reg_wen    = (w_wreg != 5'd0);
            o_mem_to_reg = (i_opcode == OP_LW);
            w_instr_done = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a  = 1'b1;
            o_alu_op     = 2'b01;
            o_pc_src     = 2'b01;
            w_pc_wen     = i_zero;
            w_instr_done = 1'b1;
         end
         S_JUMP: begin
            o_pc_src     = 2'b10;
            w_pc_wen     = 1'b1;
            w_instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are forced low while reset is held so an abandoned instruction writes nothing.
   assign o_ir_wen     = rst & w_ir_wen;
   assign o_pc_wen     = rst & w_pc_wen;
   assign o_tgt_wen    = rst & w_tgt_wen;
   assign o_mem_ren    = rst & w_mem_ren;
   assign o_mem_wen    = rst & w_mem_wen;
   assign o_reg_wen    = rst & w_reg_wen;
   assign o_instr_done = rst & w_instr_done;
   assign o_illegal    = rst & w_illegal;
   assign o_wreg       = w_wreg;
   assign o_state      = r_state;
   assign o_fault      = r_fault;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: a phase-level plan of each instruction feeds a
// per-cycle expectation queue and a retire/illegal/fault event scoreboard.
module tb_mc_control_fsm;

   localparam int TO = 4;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC   = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWR  = 4'd4;
   localparam logic [3:0] S_WB     = 4'd5;
   localparam logic [3:0] S_BRANCH = 4'd6;
   localparam logic [3:0] S_JUMP   = 4'd7;
   localparam logic [3:0] S_HALT   = 4'd8;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] i_opcode;
   logic [4:0] i_rt, i_rd;
   logic       i_zero, i_mem_ready;
   logic       o_ir_wen, o_pc_wen, o_tgt_wen, o_iord, o_mem_ren, o_mem_wen;
   logic       o_alu_src_a, o_reg_wen, o_mem_to_reg, o_instr_done, o_illegal, o_fault;
   logic [1:0] o_pc_src, o_alu_src_b, o_alu_op;
   logic [4:0] o_wreg;
   logic [3:0] o_state;

   always #5 clk = ~clk;

   mc_control_fsm #(.TIMEOUT_CYCLES(TO), .CW(16)) dut (
      .clk(clk), .rst(rst),
      .i_opcode(i_opcode), .i_rt(i_rt), .i_rd(i_rd), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
      .o_ir_wen(o_ir_wen), .o_pc_wen(o_pc_wen), .o_pc_src(o_pc_src), .o_tgt_wen(o_tgt_wen),
      .o_iord(o_iord), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
      .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
      .o_reg_wen(o_reg_wen), .o_wreg(o_wreg), .o_mem_to_reg(o_mem_to_reg),
      .o_state(o_state), .o_instr_done(o_instr_done), .o_illegal(o_illegal), .o_fault(o_fault)
   );

   typedef struct {
      logic [3:0] st;
      logic       rdy;
      logic [5:0] op;
      logic       wnz;
      logic       z;
   } cyc_t;

   typedef struct {
      int         kind;      // 0 retire, 1 illegal, 2 fault
      int         at;
      logic [3:0] st;
      logic [4:0] wreg;
      logic       reg_wen;
      logic       m2r;
      logic       pc_wen;
      logic [1:0] pc_src;
   } ev_t;

   cyc_t cyc_q[$];
   ev_t  ev_q[$];
   cyc_t plan[$];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [5:0] p_op;
   logic       p_wnz, p_z;
   bit         fault_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Expected outputs of one cycle, straight from the per-state output table.
   function automatic logic [18:0] exp_vec(input cyc_t c);
      logic a, iord, irw, tgw, mr, mw, rw, pcw, m2r;
      logic [1:0] b, aop, pcs;
      a = 0; iord = 0; irw = 0; tgw = 0; mr = 0; mw = 0; rw = 0; pcw = 0; m2r = 0;
      b = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (c.st)
         S_FETCH:  begin b = 2'b01; mr = 1; irw = c.rdy; pcw = c.rdy; end
         S_DECODE: begin b = 2'b11; tgw = 1; end
         S_EXEC:   begin a = 1; if (c.op == OP_R) aop = 2'b10; else b = 2'b10; end
         S_MEMRD:  begin mr = 1; iord = 1; end
         S_MEMWR:  begin mw = 1; iord = 1; end
         S_WB:     begin rw = c.wnz; m2r = (c.op == OP_LW); end
         S_BRANCH: begin a = 1; aop = 2'b01; pcs = 2'b01; pcw = c.z; end
         S_JUMP:   begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {c.st, a, b, aop, iord, irw, tgw, mr, mw, rw, pcw, pcs, m2r};
   endfunction

   task automatic push_plan(input logic [3:0] st, input logic rdy);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.op = p_op; c.wnz = p_wnz; c.z = p_z;
      plan.push_back(c);
   endtask

   // A wait phase of w idle cycles; more than TO idle cycles ends in HALT.
   task automatic plan_wait(input logic [3:0] st, input int w, output bit fault);
      if (w > TO) begin
         repeat (TO + 1) push_plan(st, 1'b0);
         push_plan(S_HALT, 1'($urandom_range(0, 1)));
         fault = 1;
      end else begin
         repeat (w) push_plan(st, 1'b0);
         push_plan(st, 1'b1);
         fault = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_mem_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("reset_state", 32'(o_state), 32'(S_FETCH));
      chk("reset_fault", 32'(o_fault), 32'd0);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                            input logic z, input int wf, input int wm, input int abort_at);
      ev_t ev;
      bit  fault;
      int  ev_idx, n;
      logic [4:0] wreg;
      wreg  = (op == OP_R) ? rd : rt;
      p_op  = op;
      p_wnz = (wreg != 5'd0);
      p_z   = z;
      plan.delete();
      ev.kind = 0; ev.at = 0; ev.st = 4'd0; ev.wreg = wreg;
      ev.reg_wen = 0; ev.m2r = 0; ev.pc_wen = 0; ev.pc_src = 2'b00;
      plan_wait(S_FETCH, wf, fault);
      if (!fault) begin
         push_plan(S_DECODE, 1'($urandom_range(0, 1)));
         case (op)
            OP_R, OP_ADDI: begin
               push_plan(S_EXEC, 1'($urandom_range(0, 1)));
               push_plan(S_WB, 1'($urandom_range(0, 1)));
               ev.reg_wen = p_wnz;
            end
            OP_LW: begin
               push_plan(S_EXEC, 1'($urandom_range(0, 1)));
               plan_wait(S_MEMRD, wm, fault);
               if (!fault) begin
                  push_plan(S_WB, 1'($urandom_range(0, 1)));
                  ev.reg_wen = p_wnz;
                  ev.m2r = 1;
               end
            end
            OP_SW: begin
               push_plan(S_EXEC, 1'($urandom_range(0, 1)));
               plan_wait(S_MEMWR, wm, fault);
            end
            OP_BEQ: begin
               push_plan(S_BRANCH, 1'($urandom_range(0, 1)));
               ev.pc_wen = z; ev.pc_src = 2'b01;
            end
            OP_J: begin
               push_plan(S_JUMP, 1'($urandom_range(0, 1)));
               ev.pc_wen = 1; ev.pc_src = 2'b10;
            end
            default: ev.kind = 1;
         endcase
      end
      if (fault) begin
         ev.kind = 2; ev.reg_wen = 0; ev.m2r = 0; ev.pc_wen = 0; ev.pc_src = 2'b00;
      end
      ev_idx = plan.size() - 1;
      ev.st  = plan[ev_idx].st;
      if (fault) repeat (2) push_plan(S_HALT, 1'($urandom_range(0, 1)));
      ev.at = cyc + ev_idx;
      n = (abort_at >= 0 && abort_at <= ev_idx) ? abort_at : plan.size();
      if (n == plan.size()) ev_q.push_back(ev);
      i_opcode = op; i_rt = rt; i_rd = rd; i_zero = z;
      for (int i = 0; i < n; i++) begin
         cyc_q.push_back(plan[i]);
         i_mem_ready = plan[i].rdy;
         @(posedge clk);
         #1;
      end
      if (fault || n < plan.size()) do_reset();
   endtask

   always @(negedge clk) begin : monitor
      cyc_t c;
      ev_t  e;
      logic [2:0] obs, want;
      if (!rst) begin
         chk("strobes_in_reset",
             32'({o_ir_wen, o_pc_wen, o_tgt_wen, o_mem_ren, o_mem_wen, o_reg_wen, o_instr_done, o_illegal}),
             32'd0);
         fault_seen = 0;
      end else begin
         if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("cycle_outputs",
                32'({o_state, o_alu_src_a, o_alu_src_b, o_alu_op, o_iord, o_ir_wen, o_tgt_wen,
                     o_mem_ren, o_mem_wen, o_reg_wen, o_pc_wen, o_pc_src, o_mem_to_reg}),
                32'(exp_vec(c)));
         end
         obs = {o_fault & !fault_seen, o_illegal, o_instr_done};
         if (obs != 3'b000) begin
            if (ev_q.size() == 0) begin
               chk("unexpected_event", 32'(obs), 32'd0);
            end else begin
               e = ev_q.pop_front();
               want = 3'(1 << e.kind);
               chk("event_kind", 32'(obs), 32'(want));
               chk("event_cycle", 32'(cyc), 32'(e.at));
               chk("event_state", 32'(o_state), 32'(e.st));
               chk("event_wreg", 32'(o_wreg), 32'(e.wreg));
               chk("event_reg_wen", 32'(o_reg_wen), 32'(e.reg_wen));
               chk("event_mem_to_reg", 32'(o_mem_to_reg), 32'(e.m2r));
               chk("event_pc_wen", 32'(o_pc_wen), 32'(e.pc_wen));
               chk("event_pc_src", 32'(o_pc_src), 32'(e.pc_src));
            end
         end
         if (fault_seen) chk("fault_sticky", 32'(o_fault), 32'd1);
         if (o_fault) fault_seen = 1;
      end
   end

   initial begin
      int r, wf, wm, ab;
      logic [5:0] op;
      logic [4:0] rt, rd;
      rst = 1'b0; i_opcode = 6'h0; i_rt = 5'd0; i_rd = 5'd0; i_zero = 1'b0; i_mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("reset_state", 32'(o_state), 32'(S_FETCH));
      chk("reset_fault", 32'(o_fault), 32'd0);

      run_instr(OP_ADDI, 5'd5, 5'd0, 1'b0, 0, 0, -1);
      run_instr(OP_R,    5'd7, 5'd0, 1'b0, 0, 0, -1);
      run_instr(OP_LW,   5'd9, 5'd2, 1'b0, 0, 3, -1);
      run_instr(OP_BEQ,  5'd1, 5'd2, 1'b1, 0, 0, -1);
      run_instr(OP_BEQ,  5'd1, 5'd2, 1'b0, 0, 0, -1);
      run_instr(6'h3F,   5'd3, 5'd4, 1'b0, 0, 0, -1);
      run_instr(OP_ADDI, 5'd3, 5'd0, 1'b0, TO, 0, -1);
      run_instr(OP_ADDI, 5'd3, 5'd0, 1'b0, TO + 1, 0, -1);
      run_instr(OP_SW,   5'd4, 5'd0, 1'b0, 1, TO + 1, -1);
      run_instr(OP_SW,   5'd4, 5'd0, 1'b0, 0, TO, -1);
      run_instr(OP_J,    5'd0, 5'd0, 1'b1, 2, 0, -1);
      run_instr(OP_SW,   5'd4, 5'd0, 1'b0, 0, 0, 3);
      run_instr(OP_LW,   5'd0, 5'd8, 1'b0, 1, 1, -1);

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 7);
         case (r)
            0: op = OP_R;
            1: op = OP_ADDI;
            2: op = OP_LW;
            3: op = OP_SW;
            4: op = OP_BEQ;
            5: op = OP_J;
            6: op = 6'($urandom_range(0, 63));
            default: op = OP_LW;
         endcase
         rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, TO + 2)) : int'($urandom_range(0, 1));
         wm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, TO + 2)) : int'($urandom_range(0, 2));
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(op, rt, rd, 1'($urandom_range(0, 1)), wf, wm, ab);
      end

      chk("pending_events", 32'(ev_q.size()), 32'd0);
      chk("pending_cycles", 32'(cyc_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
